// File: rtl/ucsbece154_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : ucsbece154_mem_arbiter_if
//  Purpose  : Bundle of the icache, dcache and SDRAM-controller read-side
//             signals that meet at the memory read arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface ucsbece154_mem_arbiter_if;
    // icache refill side
    logic        IReadRequest;
    logic [31:0] IReadAddress;
    logic [31:0] IDataIn;
    logic        IDataReady;
    // dcache refill side
    logic        DReadRequest;
    logic [31:0] DReadAddress;
    logic [31:0] DDataIn;
    logic        DDataReady;
    // SDRAM controller side
    logic [31:0] MemReadAddress;
    logic        MemReadRequest;
    logic [31:0] MemDataIn;
    logic        MemDataReady;
    // current burst owner
    logic [1:0]  Grant;

    // Arbiter view
    modport master (
        input  IReadRequest, IReadAddress,
        output IDataIn, IDataReady,
        input  DReadRequest, DReadAddress,
        output DDataIn, DDataReady,
        output MemReadAddress, MemReadRequest,
        input  MemDataIn, MemDataReady,
        output Grant
    );

    // Environment view (caches + SDRAM controller)
    modport slave (
        output IReadRequest, IReadAddress,
        input  IDataIn, IDataReady,
        output DReadRequest, DReadAddress,
        input  DDataIn, DDataReady,
        input  MemReadAddress, MemReadRequest,
        output MemDataIn, MemDataReady,
        input  Grant
    );
endinterface
`default_nettype wire

// File: rtl/ucsbece154_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ucsbece154_mem_arbiter
//  Purpose  : Shares the single SDRAM read port between the icache and
//             dcache refill engines, one block burst at a time, with
//             round-robin or fixed icache-first arbitration.
//  Revision : 1.0 - initial release
// ============================================================================
module ucsbece154_mem_arbiter #(
    parameter int BLOCK_WORDS = 4,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic Clk,
    input  logic Reset,
    ucsbece154_mem_arbiter_if.master bus
);

    localparam int                  c_CNT_W      = $clog2(BLOCK_WORDS);
    localparam int                  c_OFS_W      = c_CNT_W + 2;
    localparam logic [31:0]         c_ALIGN_MASK = ~((32'd1 << c_OFS_W) - 32'd1);
    localparam logic [c_CNT_W-1:0]  c_LAST       = c_CNT_W'(BLOCK_WORDS - 1);
    localparam logic [c_CNT_W-1:0]  c_ONE        = c_CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t               r_state, w_state_next;
    logic [c_CNT_W-1:0]   r_cnt, w_cnt_next;
    logic                 r_last_d, w_last_d_next;   // 1: dcache was served last
    logic                 r_mem_req, w_mem_req_next;
    logic [1:0]           r_grant, w_grant_next;
    logic [31:0]          r_mem_addr, w_mem_addr_next;
    logic                 w_pick_d;

    // Next-state logic: pick a winner in IDLE, count beats while busy.
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_last_d_next   = r_last_d;
        w_mem_req_next  = r_mem_req;
        w_grant_next    = r_grant;
        w_mem_addr_next = r_mem_addr;
        w_pick_d        = 1'b0;
        case (r_state)
            IDLE: begin
                // Strobes arriving here are ignored on purpose.
                if (bus.IReadRequest || bus.DReadRequest) begin
                    w_pick_d        = bus.DReadRequest &&
                                      (!bus.IReadRequest || (ROUND_ROBIN && !r_last_d));
                    w_state_next    = w_pick_d ? BUSY_D : BUSY_I;
                    w_mem_req_next  = 1'b1;
                    w_grant_next    = w_pick_d ? 2'b10 : 2'b01;
                    w_mem_addr_next = (w_pick_d ? bus.DReadAddress : bus.IReadAddress)
                                      & c_ALIGN_MASK;
                    w_cnt_next      = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                // The burst always runs to completion even if the requester
                // drops, since the SDRAM controller cannot abort it.
                if (bus.MemDataReady) begin
                    w_cnt_next = r_cnt + c_ONE;   // wraps to 0 on the last beat
                    if (r_cnt == c_LAST) begin
                        w_state_next   = IDLE;
                        w_mem_req_next = 1'b0;
                        w_grant_next   = 2'b00;
                        w_last_d_next  = (r_state == BUSY_D);
                    end
                end
            end
            default: begin
                w_state_next   = IDLE;
                w_mem_req_next = 1'b0;
                w_grant_next   = 2'b00;
            end
        endcase
    end

    // State register; reset drops the request and grant immediately.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_last_d   <= 1'b1;
            r_mem_req  <= 1'b0;
            r_grant    <= 2'b00;
            r_mem_addr <= 32'd0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_last_d   <= w_last_d_next;
            r_mem_req  <= w_mem_req_next;
            r_grant    <= w_grant_next;
            r_mem_addr <= w_mem_addr_next;
        end
    end

    // Beat steering is purely combinational: zero-cycle forwarding.
    assign bus.IDataIn        = bus.MemDataIn;
    assign bus.DDataIn        = bus.MemDataIn;
    assign bus.IDataReady     = bus.MemDataReady & r_grant[0];
    assign bus.DDataReady     = bus.MemDataReady & r_grant[1];
    assign bus.MemReadRequest = r_mem_req;
    assign bus.MemReadAddress = r_mem_addr;
    assign bus.Grant          = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_ucsbece154_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ucsbece154_mem_arbiter
//  Purpose  : Directed self-checking bench; bus a drives a round-robin
//             arbiter, bus b a fixed icache-first arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ucsbece154_mem_arbiter;

    logic clk;
    logic rst;

    ucsbece154_mem_arbiter_if a ();
    ucsbece154_mem_arbiter_if b ();

    ucsbece154_mem_arbiter #(.BLOCK_WORDS(4), .ROUND_ROBIN(1'b1)) u_dut_rr (
        .Clk   (clk),
        .Reset (rst),
        .bus   (a)
    );

    ucsbece154_mem_arbiter #(.BLOCK_WORDS(4), .ROUND_ROBIN(1'b0)) u_dut_fix (
        .Clk   (clk),
        .Reset (rst),
        .bus   (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  port;
        logic [31:0] data;
    } beat_t;

    typedef struct packed {
        logic [1:0]  g;
        logic [31:0] addr;
    } grant_t;

    beat_t  beat_q[$];
    grant_t grant_q[$];

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] f_ready(input bit sel);
        return sel ? {b.DDataReady, b.IDataReady} : {a.DDataReady, a.IDataReady};
    endfunction

    function automatic logic [31:0] f_data(input bit sel, input logic [1:0] port);
        if (sel) return port[1] ? b.DDataIn : b.IDataIn;
        return port[1] ? a.DDataIn : a.IDataIn;
    endfunction

    function automatic logic f_req(input bit sel);
        return sel ? b.MemReadRequest : a.MemReadRequest;
    endfunction

    function automatic logic [1:0] f_grant(input bit sel);
        return sel ? b.Grant : a.Grant;
    endfunction

    function automatic logic [31:0] f_addr(input bit sel);
        return sel ? b.MemReadAddress : a.MemReadAddress;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_mem(input bit sel, input logic rdy, input logic [31:0] d);
        if (sel) begin
            b.MemDataReady = rdy;
            b.MemDataIn    = d;
        end else begin
            a.MemDataReady = rdy;
            a.MemDataIn    = d;
        end
    endtask

    // Grant edge: from IDLE with a request pending, the next edge grants.
    task automatic grant_edge(input bit sel);
        grant_t e;
        e = grant_q.pop_front();
        tick();
        chk("grant_memreq", {31'd0, f_req(sel)}, 32'd1);
        chk("grant_owner", {30'd0, f_grant(sel)}, {30'd0, e.g});
        chk("grant_addr", f_addr(sel), e.addr);
    endtask

    // One SDRAM beat: expected steering is queued on drive, popped on strobe.
    task automatic beat(input bit sel, input logic [1:0] port, input logic [31:0] d, input bit last);
        beat_t e;
        beat_q.push_back('{port: port, data: d});
        drive_mem(sel, 1'b1, d);
        #1;
        e = beat_q.pop_front();
        chk("beat_strobe", {30'd0, f_ready(sel)}, {30'd0, e.port});
        chk("beat_data", f_data(sel, e.port), e.data);
        tick();
        drive_mem(sel, 1'b0, 32'd0);
        chk("beat_memreq", {31'd0, f_req(sel)}, {31'd0, !last});
        if (last) chk("beat_end_grant", {30'd0, f_grant(sel)}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        a.IReadRequest = 1'b0; a.IReadAddress = 32'd0;
        a.DReadRequest = 1'b0; a.DReadAddress = 32'd0;
        a.MemDataIn    = 32'd0; a.MemDataReady = 1'b0;
        b.IReadRequest = 1'b0; b.IReadAddress = 32'd0;
        b.DReadRequest = 1'b0; b.DReadAddress = 32'd0;
        b.MemDataIn    = 32'd0; b.MemDataReady = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_memreq", {31'd0, a.MemReadRequest}, 32'd0);
        chk("rst_grant", {30'd0, a.Grant}, 32'd0);
        chk("rst_addr", a.MemReadAddress, 32'd0);
        chk("rst_ready", {30'd0, f_ready(0)}, 32'd0);
        rst = 1'b0;
        tick();

        // Single icache miss
        a.IReadAddress = 32'h0000_1234;
        a.IReadRequest = 1'b1;
        grant_q.push_back('{g: 2'b01, addr: 32'h0000_1230});
        grant_edge(0);
        for (int j = 0; j < 4; j++) beat(0, 2'b01, 32'hA0 + j, j == 3);
        a.IReadRequest = 1'b0;
        tick();
        chk("t1_no_regrant", {31'd0, a.MemReadRequest}, 32'd0);
        chk("t1_addr_hold", a.MemReadAddress, 32'h0000_1230);

        // Round-robin contention from reset release
        rst = 1'b1;
        #1;
        rst = 1'b0;
        a.IReadAddress = 32'h0000_0104;
        a.DReadAddress = 32'h0000_200C;
        a.IReadRequest = 1'b1;
        a.DReadRequest = 1'b1;
        for (int k = 0; k < 4; k++)
            grant_q.push_back((k % 2 == 0) ? '{g: 2'b01, addr: 32'h0000_0100}
                                            : '{g: 2'b10, addr: 32'h0000_2000});
        for (int k = 0; k < 4; k++) begin
            grant_edge(0);
            for (int j = 0; j < 4; j++)
                beat(0, (k % 2 == 0) ? 2'b01 : 2'b10, 32'hB0 + k * 16 + j, j == 3);
        end
        a.IReadRequest = 1'b0;
        a.DReadRequest = 1'b0;
        tick();
        chk("t2_idle", {31'd0, a.MemReadRequest}, 32'd0);

        // Fixed priority: icache keeps winning while it requests
        b.IReadAddress = 32'h4444_4448;
        b.DReadAddress = 32'h0000_0030;
        b.IReadRequest = 1'b1;
        b.DReadRequest = 1'b1;
        for (int k = 0; k < 3; k++) grant_q.push_back('{g: 2'b01, addr: 32'h4444_4440});
        grant_q.push_back('{g: 2'b10, addr: 32'h0000_0030});
        for (int k = 0; k < 3; k++) begin
            grant_edge(1);
            for (int j = 0; j < 4; j++) beat(1, 2'b01, 32'hF0 + k * 16 + j, j == 3);
        end
        b.IReadRequest = 1'b0;
        grant_edge(1);
        for (int j = 0; j < 4; j++) beat(1, 2'b10, 32'h70 + j, j == 3);
        b.DReadRequest = 1'b0;
        tick();
        chk("t3_idle", {31'd0, b.MemReadRequest}, 32'd0);

        // Spurious strobe in IDLE
        drive_mem(0, 1'b1, 32'hDEAD);
        #1;
        chk("spur_ready", {30'd0, f_ready(0)}, 32'd0);
        tick();
        chk("spur_memreq", {31'd0, a.MemReadRequest}, 32'd0);
        chk("spur_grant", {30'd0, a.Grant}, 32'd0);
        drive_mem(0, 1'b0, 32'd0);

        // dcache burst at top of memory, requester drops after beat 2
        a.DReadAddress = 32'hFFFF_FFFC;
        a.DReadRequest = 1'b1;
        grant_q.push_back('{g: 2'b10, addr: 32'hFFFF_FFF0});
        grant_edge(0);
        beat(0, 2'b10, 32'hC0, 1'b0);
        beat(0, 2'b10, 32'hC1, 1'b0);
        a.DReadRequest = 1'b0;
        a.DReadAddress = 32'h0000_1000;
        beat(0, 2'b10, 32'hC2, 1'b0);
        chk("t4_addr_sampled_once", a.MemReadAddress, 32'hFFFF_FFF0);
        beat(0, 2'b10, 32'hC3, 1'b1);
        drive_mem(0, 1'b1, 32'hBEEF);
        #1;
        chk("t4_extra_beat_ready", {30'd0, f_ready(0)}, 32'd0);
        tick();
        drive_mem(0, 1'b0, 32'd0);
        chk("t4_extra_memreq", {31'd0, a.MemReadRequest}, 32'd0);
        chk("t4_addr_hold", a.MemReadAddress, 32'hFFFF_FFF0);

        // Reset mid-burst, then a full fresh burst
        a.IReadAddress = 32'h0000_0A08;
        a.IReadRequest = 1'b1;
        grant_q.push_back('{g: 2'b01, addr: 32'h0000_0A00});
        grant_edge(0);
        beat(0, 2'b01, 32'hD0, 1'b0);
        beat(0, 2'b01, 32'hD1, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_memreq", {31'd0, a.MemReadRequest}, 32'd0);
        chk("midrst_grant", {30'd0, a.Grant}, 32'd0);
        chk("midrst_addr", a.MemReadAddress, 32'd0);
        rst = 1'b0;
        #1;
        grant_q.push_back('{g: 2'b01, addr: 32'h0000_0A00});
        grant_edge(0);
        for (int j = 0; j < 4; j++) beat(0, 2'b01, 32'hE0 + j, j == 3);
        a.IReadRequest = 1'b0;
        tick();
        chk("t5_idle", {31'd0, a.MemReadRequest}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
